img2col_tile_scheduler: RTL and testbench

//  Sequences the SIZE-lane img2col_ifm_size array over a whole IFM job: walks tile grid (y outer, x, channel pass inner),

---
 rtl/img2col_tile_scheduler_pkg.sv | 6 +
 rtl/img2col_tile_scheduler_lane_addr.sv | 18 +
 rtl/img2col_tile_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_img2col_tile_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/img2col_tile_scheduler_pkg.sv
// img2col_tile_scheduler_pkg: shared FSM encoding and default geometry for the img2col tile scheduler.
package img2col_tile_scheduler_pkg;
  localparam int I2C_SIZE = 8;
  localparam int I2C_AW = 10;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, ADV, FIN} state_e;
endpackage

// File: rtl/img2col_tile_scheduler_lane_addr.sv
// img2col_lane_addr_gen: per-lane base addresses and valid mask for one channel pass.
module img2col_lane_addr_gen
  import img2col_tile_scheduler_pkg::*;
#(
  parameter int SIZE = I2C_SIZE,
  parameter int AW = I2C_AW
) (
  input  logic [AW-1:0]      pass_base,
  input  logic [AW-1:0]      group_stride,
  input  logic [3:0]         valid_num,
  output logic [SIZE*AW-1:0] base_addr,
  output logic [SIZE-1:0]    addr_valid
);
  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign addr_valid[g] = 4'(g) < valid_num;
    assign base_addr[g*AW +: AW] = addr_valid[g] ? pass_base + group_stride * AW'(g) : '0;
  end
endmodule

// File: rtl/img2col_tile_scheduler.sv
// img2col_tile_scheduler: walks tile rows, tiles and channel passes of an IFM job and issues one array start per pass.
module img2col_tile_scheduler
  import img2col_tile_scheduler_pkg::*;
#(
  parameter int SIZE = I2C_SIZE,
  parameter int AW = I2C_AW
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               job_start,
  input  logic [2:0]         cfg_ksize,
  input  logic [5:0]         cfg_tile_length,
  input  logic [5:0]         cfg_tile_height,
  input  logic [3:0]         cfg_tiles_x,
  input  logic [3:0]         cfg_tiles_y,
  input  logic [5:0]         cfg_ch_groups,
  input  logic [AW-1:0]      cfg_base,
  input  logic [AW-1:0]      cfg_tile_stride,
  input  logic [AW-1:0]      cfg_group_stride,
  input  logic               cube_ready,
  input  logic               i2c_ready,
  input  logic               i2c_done,
  output logic               i2c_ifm_start,
  output logic [2:0]         ksize,
  output logic [5:0]         tile_length,
  output logic [5:0]         tile_height,
  output logic [3:0]         valid_num,
  output logic [SIZE-1:0]    addr_valid,
  output logic [SIZE*AW-1:0] base_addr,
  output logic               job_busy,
  output logic               job_done,
  output logic [3:0]         cur_tile_x,
  output logic [3:0]         cur_tile_y
);
  localparam logic [5:0] SZ6 = 6'(SIZE);
  localparam logic [3:0] SZ4 = 4'(SIZE);
  state_e state_q, state_d;
  logic [2:0] ksize_q, ksize_d;
  logic [5:0] tlen_q, tlen_d, thgt_q, thgt_d, groups_q, groups_d, left_q, left_d;
  logic [3:0] tx_q, tx_d, ty_q, ty_d, x_q, x_d, y_q, y_d, vn_q, vn_d;
  logic [AW-1:0] tstride_q, tstride_d, gstride_q, gstride_d, pstride_q, pstride_d;
  logic [AW-1:0] tile_base_q, tile_base_d, pass_base_q, pass_base_d;
  logic [SIZE-1:0] av_q, av_d, lane_valid;
  logic [SIZE*AW-1:0] ba_q, ba_d, lane_addr;
  logic [3:0] vn_now;
  logic empty, more_pass, x_last, y_last, fire;

  img2col_lane_addr_gen #(.SIZE(SIZE), .AW(AW)) u_lane (
    .pass_base(pass_base_q),
    .group_stride(gstride_q),
    .valid_num(vn_now),
    .base_addr(lane_addr),
    .addr_valid(lane_valid)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      ksize_q <= '0;
      tlen_q <= '0;
      thgt_q <= '0;
      groups_q <= '0;
      left_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      x_q <= '0;
      y_q <= '0;
      vn_q <= '0;
      tstride_q <= '0;
      gstride_q <= '0;
      pstride_q <= '0;
      tile_base_q <= '0;
      pass_base_q <= '0;
      av_q <= '0;
      ba_q <= '0;
    end else begin
      state_q <= state_d;
      ksize_q <= ksize_d;
      tlen_q <= tlen_d;
      thgt_q <= thgt_d;
      groups_q <= groups_d;
      left_q <= left_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      x_q <= x_d;
      y_q <= y_d;
      vn_q <= vn_d;
      tstride_q <= tstride_d;
      gstride_q <= gstride_d;
      pstride_q <= pstride_d;
      tile_base_q <= tile_base_d;
      pass_base_q <= pass_base_d;
      av_q <= av_d;
      ba_q <= ba_d;
    end
  end

  always_comb begin
    empty = cfg_tiles_x == '0 || cfg_tiles_y == '0 || cfg_ch_groups == '0;
    more_pass = left_q > SZ6;
    x_last = x_q + 4'd1 == tx_q;
    y_last = y_q + 4'd1 == ty_q;
    fire = state_q == ISSUE && i2c_ready && cube_ready;
    vn_now = more_pass ? SZ4 : left_q[3:0];
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = job_start ? (empty ? FIN : LOAD) : IDLE;
      LOAD:  state_d = ISSUE;
      ISSUE: state_d = fire ? RUN : ISSUE;
      RUN:   state_d = i2c_done ? ADV : RUN;
      ADV:   state_d = (!more_pass && x_last && y_last) ? FIN : LOAD;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: config latch on accepted job_start, lane snapshot in LOAD, pass/tile stepping in ADV.
  always_comb begin
    ksize_d = ksize_q;
    tlen_d = tlen_q;
    thgt_d = thgt_q;
    groups_d = groups_q;
    left_d = left_q;
    tx_d = tx_q;
    ty_d = ty_q;
    x_d = x_q;
    y_d = y_q;
    vn_d = vn_q;
    tstride_d = tstride_q;
    gstride_d = gstride_q;
    pstride_d = pstride_q;
    tile_base_d = tile_base_q;
    pass_base_d = pass_base_q;
    av_d = av_q;
    ba_d = ba_q;
    if (state_q == IDLE && job_start) begin
      ksize_d = cfg_ksize;
      tlen_d = cfg_tile_length;
      thgt_d = cfg_tile_height;
      groups_d = cfg_ch_groups;
      left_d = cfg_ch_groups;
      tx_d = cfg_tiles_x;
      ty_d = cfg_tiles_y;
      x_d = '0;
      y_d = '0;
      tstride_d = cfg_tile_stride;
      gstride_d = cfg_group_stride;
      pstride_d = cfg_group_stride * AW'(SIZE);
      tile_base_d = cfg_base;
      pass_base_d = cfg_base;
    end
    if (state_q == LOAD) begin
      vn_d = vn_now;
      av_d = lane_valid;
      ba_d = lane_addr;
    end
    if (state_q == ADV && more_pass) begin
      left_d = left_q - SZ6;
      pass_base_d = pass_base_q + pstride_q;
    end else if (state_q == ADV && !(x_last && y_last)) begin
      left_d = groups_q;
      tile_base_d = tile_base_q + tstride_q;
      pass_base_d = tile_base_q + tstride_q;
      x_d = x_last ? 4'd0 : x_q + 4'd1;
      y_d = x_last ? y_q + 4'd1 : y_q;
    end
  end

  always_comb begin
    i2c_ifm_start = fire;
    job_done = state_q == FIN;
    job_busy = state_q != IDLE;
    ksize = ksize_q;
    tile_length = tlen_q;
    tile_height = thgt_q;
    valid_num = vn_q;
    addr_valid = av_q;
    base_addr = ba_q;
    cur_tile_x = x_q;
    cur_tile_y = y_q;
  end
endmodule

// File: tb/tb_img2col_tile_scheduler.sv
// tb_img2col_tile_scheduler: directed vectors with hand-computed expectations for the img2col tile scheduler.
module tb_img2col_tile_scheduler;
  localparam int SIZE = 8;
  localparam int AW = 10;
  logic clock = 0, rst = 1, job_start = 0;
  logic [2:0] cfg_ksize = 0;
  logic [5:0] cfg_tile_length = 0, cfg_tile_height = 0, cfg_ch_groups = 0;
  logic [3:0] cfg_tiles_x = 0, cfg_tiles_y = 0;
  logic [AW-1:0] cfg_base = 0, cfg_tile_stride = 0, cfg_group_stride = 0;
  logic cube_ready = 1, i2c_ready = 1, i2c_done = 0;
  logic i2c_ifm_start, job_busy, job_done;
  logic [2:0] ksize;
  logic [5:0] tile_length, tile_height;
  logic [3:0] valid_num, cur_tile_x, cur_tile_y;
  logic [SIZE-1:0] addr_valid;
  logic [SIZE*AW-1:0] base_addr;
  int checks = 0, failures = 0;
  logic [SIZE*AW-1:0] rec_ba[16];
  logic [SIZE-1:0] rec_av[16];
  logic [3:0] rec_vn[16], rec_x[16], rec_y[16];

  img2col_tile_scheduler #(.SIZE(SIZE), .AW(AW)) dut (
    .clock(clock), .rst(rst), .job_start(job_start), .cfg_ksize(cfg_ksize),
    .cfg_tile_length(cfg_tile_length), .cfg_tile_height(cfg_tile_height),
    .cfg_tiles_x(cfg_tiles_x), .cfg_tiles_y(cfg_tiles_y), .cfg_ch_groups(cfg_ch_groups),
    .cfg_base(cfg_base), .cfg_tile_stride(cfg_tile_stride), .cfg_group_stride(cfg_group_stride),
    .cube_ready(cube_ready), .i2c_ready(i2c_ready), .i2c_done(i2c_done),
    .i2c_ifm_start(i2c_ifm_start), .ksize(ksize), .tile_length(tile_length),
    .tile_height(tile_height), .valid_num(valid_num), .addr_valid(addr_valid),
    .base_addr(base_addr), .job_busy(job_busy), .job_done(job_done),
    .cur_tile_x(cur_tile_x), .cur_tile_y(cur_tile_y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [SIZE*AW-1:0] lanes(input logic [AW-1:0] base, input logic [AW-1:0] gs, input int vn);
    logic [SIZE*AW-1:0] r;
    logic [AW-1:0] a;
    r = '0;
    for (int i = 0; i < vn; i++) begin
      a = base + AW'(i) * gs;
      r[i*AW +: AW] = a;
    end
    return r;
  endfunction

  task automatic start_job(input logic [2:0] ks, input logic [3:0] tx, input logic [3:0] ty, input logic [5:0] g,
                           input logic [AW-1:0] base, input logic [AW-1:0] ts, input logic [AW-1:0] gs);
    cfg_ksize = ks; cfg_tiles_x = tx; cfg_tiles_y = ty; cfg_ch_groups = g;
    cfg_base = base; cfg_tile_stride = ts; cfg_group_stride = gs;
    cfg_tile_length = 6'd12; cfg_tile_height = 6'd9;
    job_start = 1;
    tick;
    job_start = 0;
  endtask

  task automatic run_job(output int n);
    bit seen;
    n = 0;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (i2c_ifm_start) begin
        if (n < 16) begin
          rec_ba[n] = base_addr; rec_av[n] = addr_valid; rec_vn[n] = valid_num;
          rec_x[n] = cur_tile_x; rec_y[n] = cur_tile_y;
        end
        n++;
        tick;
        tick;
        i2c_done = 1;
        tick;
        i2c_done = 0;
      end else if (job_done) seen = 1;
      else tick;
    end
    check("job_done_reached", seen, 1);
    tick;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !job_done; i++) tick;
    check(tag, job_done, 1);
    tick;
  endtask

  initial begin
    int n;
    bit no_start;
    repeat (3) tick;
    rst = 0;
    check("reset_busy", job_busy, 0);
    check("reset_done", job_done, 0);
    check("reset_start", i2c_ifm_start, 0);
    check("reset_base_addr", base_addr, 0);
    check("reset_valid", {valid_num, addr_valid}, 0);

    // 1: single tile, one full pass
    start_job(3'd3, 4'd1, 4'd1, 6'd8, 10'h010, 10'h000, 10'h004);
    check("t1_busy", job_busy, 1);
    run_job(n);
    check("t1_starts", n, 1);
    check("t1_lane7", rec_ba[0][7*AW +: AW], 10'h02C);
    check("t1_base_addr", rec_ba[0], lanes(10'h010, 10'h004, 8));
    check("t1_addr_valid", rec_av[0], 8'hFF);
    check("t1_valid_num", rec_vn[0], 8);
    check("t1_ksize", ksize, 3);
    check("t1_tile_dims", {tile_length, tile_height}, {6'd12, 6'd9});
    check("t1_idle", job_busy, 0);

    // 2: 11 groups split 8 + 3
    start_job(3'd1, 4'd1, 4'd1, 6'd11, 10'h100, 10'h000, 10'h002);
    run_job(n);
    check("t2_starts", n, 2);
    check("t2_p0_vn", rec_vn[0], 8);
    check("t2_p0_mask", rec_av[0], 8'hFF);
    check("t2_p0_addr", rec_ba[0], lanes(10'h100, 10'h002, 8));
    check("t2_p1_vn", rec_vn[1], 3);
    check("t2_p1_mask", rec_av[1], 8'h07);
    check("t2_p1_lane2", rec_ba[1][2*AW +: AW], 10'h114);
    check("t2_p1_lane3", rec_ba[1][3*AW +: AW], 0);
    check("t2_p1_addr", rec_ba[1], lanes(10'h110, 10'h002, 3));

    // 3: 2x3 tiles, raster order
    start_job(3'd5, 4'd2, 4'd3, 6'd8, 10'h000, 10'h040, 10'h001);
    run_job(n);
    check("t3_starts", n, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_tile%0d_base", k), rec_ba[k][AW-1:0], 10'(k * 'h40));
      check($sformatf("t3_tile%0d_x", k), rec_x[k], k % 2);
      check($sformatf("t3_tile%0d_y", k), rec_y[k], k / 2);
    end

    // 4: cube backpressure and spurious done
    cube_ready = 0;
    start_job(3'd2, 4'd1, 4'd1, 6'd4, 10'h020, 10'h000, 10'h008);
    tick;
    no_start = 1;
    for (int i = 0; i < 20; i++) begin
      if (i2c_ifm_start) no_start = 0;
      i2c_done = (i == 5);
      tick;
    end
    i2c_done = 0;
    check("t4_no_start_while_blocked", no_start, 1);
    check("t4_held_vn", valid_num, 4);
    cube_ready = 1;
    #1;
    check("t4_start_on_ready", i2c_ifm_start, 1);
    tick;
    check("t4_start_one_cycle", i2c_ifm_start, 0);
    tick;
    i2c_done = 1;
    tick;
    i2c_done = 0;
    wait_done("t4_done");

    // 5: empty job, then job_start while busy
    start_job(3'd4, 4'd0, 4'd2, 6'd8, 10'h000, 10'h000, 10'h001);
    check("t5_empty_done", job_done, 1);
    check("t5_empty_no_start", i2c_ifm_start, 0);
    tick;
    check("t5_empty_done_pulse", job_done, 0);
    start_job(3'd3, 4'd1, 4'd1, 6'd8, 10'h000, 10'h000, 10'h001);
    cfg_ksize = 3'd7;
    cfg_tiles_x = 4'd0;
    job_start = 1;
    tick;
    job_start = 0;
    check("t5_busy_start_ignored", ksize, 3);
    run_job(n);
    check("t5_busy_job_starts", n, 1);

    // 6: address wrap, then reset in RUN
    start_job(3'd3, 4'd1, 4'd1, 6'd8, 10'h3F0, 10'h000, 10'h020);
    tick;
    check("t6_start", i2c_ifm_start, 1);
    check("t6_lane0", base_addr[AW-1:0], 10'h3F0);
    check("t6_lane1_wrap", base_addr[AW +: AW], 10'h010);
    tick;
    rst = 1;
    tick;
    rst = 0;
    check("t6_rst_busy", job_busy, 0);
    check("t6_rst_outs", {ksize, tile_length, tile_height, valid_num, addr_valid, cur_tile_x, cur_tile_y}, 0);
    check("t6_rst_base", base_addr, 0);
    no_start = 1;
    for (int i = 0; i < 5; i++) begin
      i2c_done = (i == 0);
      if (job_done || i2c_ifm_start) no_start = 0;
      tick;
    end
    i2c_done = 0;
    check("t6_no_done_after_rst", no_start, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
